// File: rtl/misr_pkg.sv
// Shared types and defaults for the MISR response compactor.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^17 + x^14 + 1, with the x^17 term implicit
  localparam logic [16:0] POLY_DEFAULT = 17'h04001;

endpackage

// File: rtl/misr_compactor_if.sv
// Response-beat handshake between an adder under test and the compactor.
interface misr_compactor_if #(
  parameter int N = 16
);
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] sum;
  logic         co;

  modport master (output resp_valid, sum, co, input  resp_ready);
  modport slave  (input  resp_valid, sum, co, output resp_ready);
endinterface

// File: rtl/misr_core.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in d.
module misr_core
  import misr_pkg::*;
#(
  parameter int           W    = 17,
  parameter logic [W-1:0] POLY = POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig[W-2:0], 1'b0} ^ d ^ (POLY & {W{sig[W-1]}});
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/misr_compactor.sv
// Session FSM, beat counter and golden compare around the MISR datapath.
module misr_compactor
  import misr_pkg::*;
#(
  parameter int           N     = 16,
  parameter logic [N:0]   POLY  = POLY_DEFAULT,
  parameter int           CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [N:0]       golden,
  misr_compactor_if.slave  resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N:0]       signature
);

  localparam int W = N + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_lat, cnt_inc;
  logic [W-1:0]     gold_lat, d, sig_nxt;
  logic             pass_r, ready, accept, start_ok, last_beat;

  assign d         = {resp.co, resp.sum};
  assign ready     = (state == RUN);
  assign accept    = resp.resp_valid && ready;
  assign start_ok  = start && (state != RUN);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_beat = (cnt_inc == cnt_lat);

  assign resp.resp_ready = ready;
  assign busy            = (state == RUN);
  assign done            = (state == DONE);
  assign pass            = pass_r;

  // Mirrors the core's update so pass can be registered on the same edge
  // that moves the FSM into DONE.
  always_comb begin
    sig_nxt = {signature[W-2:0], 1'b0} ^ d ^ (POLY & {W{signature[W-1]}});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (pattern_count == '0) ? DONE : RUN;
      RUN:        if (accept && last_beat) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cnt_lat  <= '0;
      gold_lat <= '0;
      pass_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        cnt      <= '0;
        cnt_lat  <= pattern_count;
        gold_lat <= golden;
        pass_r   <= (pattern_count == '0) && (golden == '0);
      end else if (accept) begin
        cnt <= cnt_inc;
        if (last_beat) pass_r <= (sig_nxt == gold_lat);
      end
    end
  end

  misr_core #(.W(W), .POLY(POLY)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (accept),
    .d     (d),
    .sig   (signature)
  );

endmodule

// File: tb/tb_misr_compactor.sv
// Directed checks of misr_compactor with hand-computed signatures.
module tb_misr_compactor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern_count;
  logic [16:0] golden;
  logic        busy, done, pass;
  logic [16:0] signature;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  misr_compactor_if #(.N(16)) bus ();

  misr_compactor #(.N(16), .POLY(17'h04001), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern_count (pattern_count),
    .golden        (golden),
    .resp          (bus.slave),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // busy, done, pass, resp_ready packed for compact status checks
  function automatic logic [3:0] status();
    return {busy, done, pass, bus.resp_ready};
  endfunction

  task automatic beat(input logic co_i, input logic [15:0] sum_i);
    bus.resp_valid = 1'b1;
    bus.co         = co_i;
    bus.sum        = sum_i;
    tick();
    bus.resp_valid = 1'b0;
  endtask

  task automatic begin_session(input logic [15:0] cnt_i, input logic [16:0] gold_i);
    start         = 1'b1;
    pattern_count = cnt_i;
    golden        = gold_i;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern_count = '0; golden = '0;
    bus.resp_valid = 1'b0; bus.co = 1'b0; bus.sum = '0;
    tick(); tick();
    check("reset_status", 32'(status()), 32'h0);
    check("reset_sig", 32'(signature), 32'h0);
    rst = 1'b0;

    // resp_valid in IDLE is ignored
    beat(1'b1, 16'hFFFF);
    check("idle_valid_sig", 32'(signature), 32'h0);
    check("idle_valid_status", 32'(status()), 32'h0);

    // single beat
    begin_session(16'd1, 17'h00001);
    check("single_run_status", 32'(status()), 32'b1001);
    beat(1'b0, 16'h0001);
    check("single_sig", 32'(signature), 32'h00001);
    check("single_status", 32'(status()), 32'b0110);

    // feedback with start ignored during RUN
    begin_session(16'd2, 17'h04001);
    check("fb_clear_sig", 32'(signature), 32'h0);
    beat(1'b1, 16'h0000);
    check("fb_beat1_sig", 32'(signature), 32'h10000);
    begin_session(16'd1, 17'h00000);
    check("run_start_status", 32'(status()), 32'b1001);
    check("run_start_sig", 32'(signature), 32'h10000);
    beat(1'b0, 16'h0000);
    check("fb_done_sig", 32'(signature), 32'h04001);
    check("fb_done_status", 32'(status()), 32'b0110);

    // resp_valid in DONE is ignored and the result holds
    beat(1'b1, 16'h1234);
    check("done_valid_sig", 32'(signature), 32'h04001);
    check("done_hold_status", 32'(status()), 32'b0110);

    // mismatch with stall, started from DONE
    begin_session(16'd2, 17'h04000);
    beat(1'b1, 16'h0000);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("stall_sig", 32'(signature), 32'h10000);
      check("stall_status", 32'(status()), 32'b1001);
    end
    beat(1'b0, 16'h0000);
    check("mm_sig", 32'(signature), 32'h04001);
    check("mm_status", 32'(status()), 32'b0100);

    // three beats, third with feedback
    begin_session(16'd3, 17'h0400C);
    beat(1'b0, 16'h0003);
    check("b3_1_sig", 32'(signature), 32'h00003);
    beat(1'b1, 16'h0000);
    check("b3_2_sig", 32'(signature), 32'h10006);
    check("b3_2_status", 32'(status()), 32'b1001);
    beat(1'b0, 16'h0001);
    check("b3_3_sig", 32'(signature), 32'h0400C);
    check("b3_3_status", 32'(status()), 32'b0110);

    // zero count, golden zero and nonzero
    begin_session(16'd0, 17'h00000);
    check("zero_pass_status", 32'(status()), 32'b0110);
    check("zero_sig", 32'(signature), 32'h0);
    begin_session(16'd0, 17'h00005);
    check("zero_fail_status", 32'(status()), 32'b0100);

    // reset mid-run
    begin_session(16'd4, 17'h00000);
    beat(1'b0, 16'h0003);
    beat(1'b0, 16'h0005);
    check("pre_rst_sig", 32'(signature), 32'h00003);
    rst = 1'b1;
    start = 1'b1;
    bus.resp_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_status", 32'(status()), 32'h0);
    check("rst_sig", 32'(signature), 32'h0);
    bus.co = 1'b1; bus.sum = 16'hAAAA;
    tick();
    bus.resp_valid = 1'b0;
    check("post_rst_sig", 32'(signature), 32'h0);
    check("post_rst_status", 32'(status()), 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
